cim_inst_decoder: RTL and testbench
===================================

Name: cim_inst_decoder

Overview:
- Receiving end of the CIM instruction format: accepts 32-bit instruction words {op[31:24], s1[23:16], s2[15:8], d1[7:0]} over a valid/ready handshake.
- Decodes each word and sequences row reads and writes on a 256-row CIM array to execute bitwise row operations d1 = f(s1, s2).
- Sits between the host instruction queue and the CIM array row port.
- Executes one instruction at a time, with no overlap between instructions.

Parameters:
- ROW_WIDTH, 64, bits per CIM row (data width of the array port).
- ADDR_WIDTH, 8, row address width (256 rows; every address is legal).
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- inst_valid  in  1  instruction word valid.
- inst_ready  out  1  decoder can accept; high only in IDLE.
- inst_data  in  32  instruction word: op[31:24], s1[23:16], s2[15:8], d1[7:0].
- arr_rd_en  out  1  row read strobe.
- arr_rd_addr  out  ADDR_WIDTH  row read address.
- arr_rd_data  in  ROW_WIDTH  read data, valid exactly 1 cycle after arr_rd_en.
- arr_wr_en  out  1  row write strobe.
- arr_wr_addr  out  ADDR_WIDTH  row write address.
- arr_wr_data  out  ROW_WIDTH  row write data.
- done  out  1  one-cycle pulse when an instruction retires.
- busy  out  1  high whenever state != IDLE.
- err_illegal  out  1  sticky illegal-opcode flag.
- err_clr  in  1  clears err_illegal.
- retired_cnt  out  CNT_WIDTH  count of retired instructions (incl. NOP/illegal); wraps to 0.

Behaviour:
- Reset (rst_n=0 sampled at edge):
  - State goes to IDLE.
  - inst_ready=1 from the first cycle after reset; all other outputs=0, including err_illegal and retired_cnt.
  - Any in-flight instruction is abandoned; no write is issued.
- Opcodes:
  - 0x00 NOP.
  - 0x01 AND: d1=s1&s2.
  - 0x02 OR: d1=s1|s2.
  - 0x03 XOR: d1=s1^s2.
  - 0x04 NOT: d1=~s1.
  - 0x05 COPY: d1=s1.
  - All other opcodes are illegal.
- Accept: in IDLE, inst_valid&&inst_ready at edge T0 latches all four fields. inst_data is ignored outside IDLE.
- States: IDLE, RD_S1, RD_S2, CAPT, WR, RETIRE.
- Binary ops (AND/OR/XOR):
  - T1 RD_S1: arr_rd_en=1, addr=s1.
  - T2 RD_S2: arr_rd_en=1, addr=s2; capture s1 data.
  - T3 CAPT: capture s2 data.
  - T4 WR: arr_wr_en=1, addr=d1, data=result; done=1.
  - T5: IDLE, inst_ready=1.
- Unary ops (NOT/COPY):
  - T1 RD_S1.
  - T2 CAPT: capture s1 data.
  - T3 WR with done=1.
  - T4: IDLE. The s2 field is ignored.
- NOP: T1 RETIRE with done=1, no array access; T2 IDLE.
- Illegal opcode: T1 RETIRE with done=1; err_illegal set at the end of T1; no array access.
- Output gating:
  - arr_rd_en/arr_wr_en are high only in the states listed above.
  - arr_rd_addr/arr_wr_addr/arr_wr_data are 0 when their strobe is low.
- Counter: retired_cnt increments by 1 on every done pulse; all-ones wraps to 0.
- err_clr: clears err_illegal at the edge. If a set and a clear occur in the same cycle, set wins.
- Aliasing: s1==s2 and/or d1==s1/s2 are legal. All reads complete before the write, so the result uses pre-instruction row contents.
- busy=1 in every non-IDLE state; busy and inst_ready are always complementary.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → inst_ready=1, busy=0, done=0, err_illegal=0, retired_cnt=0, no strobes.
- XOR: array row 3=0xFF00FF00FF00FF00, row 7=0x0F0F0F0F0F0F0F0F; issue 0x03030709.
  - Reads 3 then 7 at T1 and T2.
  - arr_wr_en at T4 with addr 9, data 0xF00FF00FF00FF00F, done at T4.
  - inst_ready returns at T5; retired_cnt=1.
- NOT with aliasing: row 5=0x0000000000000001; issue 0x04050005.
  - Single read of 5; write at T3 to row 5 with data 0xFFFFFFFFFFFFFFFE.
  - No read of row 0.
- Illegal opcode and clear: issue 0xA5000000 → done at T1, no array strobes, err_illegal=1 from T2.
  - Pulse err_clr alone → err_illegal=0.
  - Repeat with err_clr asserted in the same cycle as the set → err_illegal=1.
- Back-to-back with mid-operation reset:
  - Hold inst_valid high with AND then NOP → second instruction is accepted only when inst_ready=1 (T5).
  - Assert rst_n=0 during RD_S2 of a further AND → no arr_wr_en ever issued; IDLE next cycle.
- Counter wrap: preload via 65535 NOPs → retired_cnt=0xFFFF; one more NOP → 0x0000.

Source files
------------

// File: rtl/cim_inst_decoder.sv
// CIM row-op decoder: accepts {op,s1,s2,d1}, reads source rows, writes d1 = f(s1,s2); one instruction at a time.
// Accept->done: 4 cycles binary, 3 unary, 1 NOP/illegal; inst_ready is low until the sequence returns to IDLE.
module cim_inst_decoder #(
   parameter int ROW_WIDTH  = 64,
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inst_valid,
   output logic                  inst_ready,
   input  logic [31:0]           inst_data,
   output logic                  arr_rd_en,
   output logic [ADDR_WIDTH-1:0] arr_rd_addr,
   input  logic [ROW_WIDTH-1:0]  arr_rd_data,
   output logic                  arr_wr_en,
   output logic [ADDR_WIDTH-1:0] arr_wr_addr,
   output logic [ROW_WIDTH-1:0]  arr_wr_data,
   output logic                  done,
   output logic                  busy,
   output logic                  err_illegal,
   input  logic                  err_clr,
   output logic [CNT_WIDTH-1:0]  retired_cnt
);
   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_NOT  = 8'h04;
   localparam logic [7:0] OP_COPY = 8'h05;

   typedef enum logic [2:0] {IDLE, RD_S1, RD_S2, CAPT, WR, RETIRE} state_t;

   state_t                state_q, state_d;
   logic [7:0]            op_q, op_d;
   logic [ADDR_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, d1_q, d1_d;
   logic [ROW_WIDTH-1:0]  a_q, a_d, b_q, b_d, result;
   logic                  err_q, err_d, err_set;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   function automatic logic is_bin(input logic [7:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
   endfunction

   function automatic logic is_un(input logic [7:0] op);
      return (op == OP_NOT) || (op == OP_COPY);
   endfunction

   always_comb begin
      case (op_q)
         OP_AND:  result = a_q & b_q;
         OP_OR:   result = a_q | b_q;
         OP_XOR:  result = a_q ^ b_q;
         OP_NOT:  result = ~a_q;
         OP_COPY: result = a_q;
         default: result = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      s1_d        = s1_q;
      s2_d        = s2_q;
      d1_d        = d1_q;
      a_d         = a_q;
      b_d         = b_q;
      err_set     = 1'b0;
      inst_ready  = 1'b0;
      arr_rd_en   = 1'b0;
      arr_rd_addr = '0;
      arr_wr_en   = 1'b0;
      arr_wr_addr = '0;
      arr_wr_data = '0;
      done        = 1'b0;
      case (state_q)
         IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) begin
               op_d = inst_data[31:24];
               s1_d = ADDR_WIDTH'(inst_data[23:16]);
               s2_d = ADDR_WIDTH'(inst_data[15:8]);
               d1_d = ADDR_WIDTH'(inst_data[7:0]);
               if (is_bin(inst_data[31:24]) || is_un(inst_data[31:24])) state_d = RD_S1;
               else                                                      state_d = RETIRE;
            end
         end
         RD_S1: begin
            arr_rd_en   = 1'b1;
            arr_rd_addr = s1_q;
            state_d     = is_bin(op_q) ? RD_S2 : CAPT;
         end
         RD_S2: begin
            arr_rd_en   = 1'b1;
            arr_rd_addr = s2_q;
            a_d         = arr_rd_data;
            state_d     = CAPT;
         end
         CAPT: begin
            // Read data here belongs to s2 for binary ops, s1 for unary ops.
            if (is_bin(op_q)) b_d = arr_rd_data;
            else              a_d = arr_rd_data;
            state_d = WR;
         end
         WR: begin
            arr_wr_en   = 1'b1;
            arr_wr_addr = d1_q;
            arr_wr_data = result;
            done        = 1'b1;
            state_d     = IDLE;
         end
         RETIRE: begin
            done    = 1'b1;
            err_set = (op_q != OP_NOP);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy  = (state_q != IDLE);
      err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
      cnt_d = done ? cnt_q + CNT_WIDTH'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         d1_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         d1_q    <= d1_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign err_illegal = err_q;
   assign retired_cnt = cnt_q;
endmodule

// File: tb/tb_cim_inst_decoder.sv
// Bench for cim_inst_decoder: directed scenarios plus random instructions against a row-level reference model.
module tb_cim_inst_decoder;
   localparam int RW = 64;
   localparam int AW = 8;
   // Narrow counter keeps the wrap scenario short; the wrap rule is width-generic.
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          inst_valid = 1'b0;
   logic          inst_ready;
   logic [31:0]   inst_data = '0;
   logic          arr_rd_en;
   logic [AW-1:0] arr_rd_addr;
   logic [RW-1:0] arr_rd_data;
   logic          arr_wr_en;
   logic [AW-1:0] arr_wr_addr;
   logic [RW-1:0] arr_wr_data;
   logic          done, busy, err_illegal;
   logic          err_clr = 1'b0;
   logic [CW-1:0] retired_cnt;

   cim_inst_decoder #(.ROW_WIDTH(RW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .arr_rd_en(arr_rd_en), .arr_rd_addr(arr_rd_addr), .arr_rd_data(arr_rd_data),
      .arr_wr_en(arr_wr_en), .arr_wr_addr(arr_wr_addr), .arr_wr_data(arr_wr_data),
      .done(done), .busy(busy), .err_illegal(err_illegal), .err_clr(err_clr),
      .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   // Array responder: read data appears one cycle after the strobe.
   logic [RW-1:0] mem [256];
   logic [RW-1:0] rd_q;
   logic          pl_en = 1'b0;
   logic [7:0]    pl_addr = '0;
   logic [RW-1:0] pl_data = '0;
   always @(posedge clk) begin
      if (pl_en)     mem[pl_addr]     <= pl_data;
      if (arr_wr_en) mem[arr_wr_addr] <= arr_wr_data;
      if (arr_rd_en) rd_q             <= mem[arr_rd_addr];
   end
   assign arr_rd_data = rd_q;

   // Reference model state
   logic [RW-1:0] ref_mem [256];
   int            ref_cnt = 0;
   bit            ref_err = 1'b0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [RW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      ref_mem[a] = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (inst_ready !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check("ready_wait", 64'(inst_ready), 64'(1));
   endtask

   task automatic bump_cnt();
      ref_cnt = (ref_cnt + 1) % (1 << CW);
   endtask

   // Issue one instruction and check every cycle until it retires, then the return to IDLE.
   task automatic run_inst(input logic [31:0] w, input bit clr_at_set);
      logic [7:0]    op, s1, s2, d1;
      logic [RW-1:0] a, b, res;
      int            nrd, tdone;
      bit            has_wr, illegal;
      op = w[31:24]; s1 = w[23:16]; s2 = w[15:8]; d1 = w[7:0];
      a = ref_mem[s1]; b = ref_mem[s2];
      illegal = 1'b0; has_wr = 1'b1; res = '0;
      case (op)
         8'h01: begin nrd = 2; tdone = 4; res = a & b; end
         8'h02: begin nrd = 2; tdone = 4; res = a | b; end
         8'h03: begin nrd = 2; tdone = 4; res = a ^ b; end
         8'h04: begin nrd = 1; tdone = 3; res = ~a;    end
         8'h05: begin nrd = 1; tdone = 3; res = a;     end
         default: begin nrd = 0; tdone = 1; has_wr = 1'b0; illegal = (op != 8'h00); end
      endcase
      wait_ready();
      inst_valid = 1'b1;
      inst_data  = w;
      tick();
      inst_valid = 1'b0;
      inst_data  = $urandom;
      for (int t = 1; t <= tdone; t++) begin
         if (t == 1) err_clr = clr_at_set;
         check("rd_en",   64'(arr_rd_en),   64'(t <= nrd));
         check("rd_addr", 64'(arr_rd_addr), (t == 1 && nrd >= 1) ? 64'(s1) : (t == 2 && nrd == 2) ? 64'(s2) : 64'(0));
         check("wr_en",   64'(arr_wr_en),   64'(has_wr && t == tdone));
         check("wr_addr", 64'(arr_wr_addr), (has_wr && t == tdone) ? 64'(d1) : 64'(0));
         check("wr_data", 64'(arr_wr_data), (has_wr && t == tdone) ? 64'(res) : 64'(0));
         check("done",    64'(done),        64'(t == tdone));
         check("busy",    64'(busy),        64'(1));
         check("ready_lo", 64'(inst_ready), 64'(0));
         check("err_pre", 64'(err_illegal), 64'(ref_err));
         tick();
         if (t == 1) begin
            ref_err = illegal ? 1'b1 : (clr_at_set ? 1'b0 : ref_err);
            err_clr = 1'b0;
         end
      end
      if (has_wr) ref_mem[d1] = res;
      bump_cnt();
      check("ready_ret", 64'(inst_ready),  64'(1));
      check("busy_ret",  64'(busy),        64'(0));
      check("done_ret",  64'(done),        64'(0));
      check("cnt",       64'(retired_cnt), 64'(ref_cnt));
      check("err_post",  64'(err_illegal), 64'(ref_err));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [7:0]  op;
      // Reset held for three edges
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_ready", 64'(inst_ready),  64'(1));
      check("rst_busy",  64'(busy),        64'(0));
      check("rst_done",  64'(done),        64'(0));
      check("rst_err",   64'(err_illegal), 64'(0));
      check("rst_cnt",   64'(retired_cnt), 64'(0));
      check("rst_rd",    64'(arr_rd_en),   64'(0));
      check("rst_wr",    64'(arr_wr_en),   64'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 256; i++) preload(8'(i), {$urandom, $urandom});
      preload(8'd3, 64'hFF00FF00FF00FF00);
      preload(8'd7, 64'h0F0F0F0F0F0F0F0F);
      preload(8'd5, 64'h0000000000000001);

      // XOR, then NOT aliasing its own source
      run_inst(32'h03030709, 1'b0);
      check("xor_row9", mem[9], 64'hF00FF00FF00FF00F);
      run_inst(32'h04050005, 1'b0);
      check("not_row5", mem[5], 64'hFFFFFFFFFFFFFFFE);

      // Illegal opcode, lone clear, then clear colliding with set
      run_inst(32'hA5000000, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      ref_err = 1'b0;
      check("err_cleared", 64'(err_illegal), 64'(ref_err));
      run_inst(32'hA5000000, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      ref_err = 1'b0;

      // Back-to-back: valid held high, second word only taken once ready returns
      wait_ready();
      inst_valid = 1'b1;
      inst_data  = 32'h0103070A;
      tick();
      inst_data  = 32'h00000000;
      for (int t = 1; t <= 4; t++) begin
         check("b2b_ready_lo", 64'(inst_ready), 64'(0));
         check("b2b_wr",       64'(arr_wr_en),  64'(t == 4));
         check("b2b_done",     64'(done),       64'(t == 4));
         tick();
      end
      ref_mem[8'h0A] = ref_mem[3] & ref_mem[7];
      bump_cnt();
      check("b2b_ready_t5", 64'(inst_ready), 64'(1));
      tick();
      inst_valid = 1'b0;
      check("b2b_nop_done", 64'(done),      64'(1));
      check("b2b_nop_rd",   64'(arr_rd_en), 64'(0));
      check("b2b_nop_wr",   64'(arr_wr_en), 64'(0));
      tick();
      bump_cnt();
      check("b2b_cnt", 64'(retired_cnt), 64'(ref_cnt));
      check("b2b_row", mem[8'h0A], ref_mem[8'h0A]);

      // Random instructions over a small address window to force aliasing
      for (int i = 0; i < 60; i++) begin
         op = 8'($urandom_range(0, 7));
         if (op > 8'd5) op = 8'($urandom_range(6, 255));
         w = {op, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
         run_inst(w, $urandom_range(0, 3) == 0);
      end
      for (int r = 0; r < 16; r++) check("rand_row", mem[r], ref_mem[r]);

      // Reset during RD_S2 abandons the instruction
      wait_ready();
      inst_valid = 1'b1;
      inst_data  = 32'h01020304;
      tick();
      inst_valid = 1'b0;
      tick();
      check("mid_rd_addr", 64'(arr_rd_addr), 64'(3));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ref_cnt = 0;
      ref_err = 1'b0;
      check("mid_ready", 64'(inst_ready),  64'(1));
      check("mid_busy",  64'(busy),        64'(0));
      check("mid_cnt",   64'(retired_cnt), 64'(ref_cnt));
      check("mid_err",   64'(err_illegal), 64'(ref_err));
      for (int t = 0; t < 6; t++) begin
         check("mid_no_wr", 64'(arr_wr_en), 64'(0));
         tick();
      end
      check("mid_row4", mem[4], ref_mem[4]);

      // Counter wrap via NOPs
      while (ref_cnt != (1 << CW) - 1) run_inst(32'h00000000, 1'b0);
      check("cnt_full", 64'(retired_cnt), 64'((1 << CW) - 1));
      run_inst(32'h00000000, 1'b0);
      check("cnt_wrap", 64'(retired_cnt), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
